front_panel_switches: RTL and testbench

FRONT_PANEL_SWITCHES -- requirements
Module: front_panel_switches

---
 rtl/front_panel_switches.sv | 111 +++++++++++
 tb/tb_front_panel_switches.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/front_panel_switches.sv
// Front-panel switch conditioning: per-bit synchronizer and debounce, then a
// rising-edge command interlock that issues one pulse per press.
module front_panel_switches #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw_in,
  output logic [7:0] sw_level,
  output logic [7:0] sw_pulse,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, HELD} state_t;

  logic [7:0] sync1_reg;
  logic [7:0] sync2_reg;
  logic [7:0] prev_level_reg;
  logic [7:0] pulse_reg;
  logic [7:0] pulse_next;
  logic [7:0] rise;
  logic [6:0] rise_hi;
  logic [6:0] first_hi;
  state_t     state_reg;
  state_t     state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_in;
      sync2_reg <= sync1_reg;
    end
  end

  // The counter only runs while the synchronized input disagrees with the
  // accepted level, so it can never pass CNT_MAX.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
      logic [CW-1:0] cnt_reg;
      logic          level_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync2_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_reg   <= '0;
          level_reg <= sync2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign sw_level[gi] = level_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_level_reg <= '0;
    end else begin
      prev_level_reg <= sw_level;
    end
  end

  assign rise     = sw_level & ~prev_level_reg;
  assign rise_hi  = rise[7:1];
  // Isolate the lowest set bit so simultaneous presses yield a single command.
  assign first_hi = rise_hi & (~rise_hi + 7'd1);

  always_comb begin
    state_next    = state_reg;
    pulse_next    = '0;
    pulse_next[0] = rise[0];
    case (state_reg)
      IDLE: begin
        if (rise_hi != '0) begin
          pulse_next[7:1] = first_hi;
          state_next      = HELD;
        end
      end
      HELD: begin
        if (sw_level[7:1] == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pulse_reg <= '0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= pulse_next;
    end
  end

  assign sw_pulse = pulse_reg;
  assign busy     = (state_reg == HELD);

endmodule

// File: tb/tb_front_panel_switches.sv
// Randomized bench for front_panel_switches: a window-based reference model
// predicts levels, busy and pulses; a monitor checks pulses from a scoreboard.
module tb_front_panel_switches;

  localparam int N    = 4;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] sw_level;
  logic [7:0] sw_pulse;
  logic       busy;

  always #5 clk = ~clk;

  front_panel_switches #(.DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .sw_level (sw_level),
    .sw_pulse (sw_pulse),
    .busy     (busy)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [7:0] raw_h [0:MAXC-1];
  bit         rst_h [0:MAXC-1];
  logic [7:0] d_h   [0:MAXC-1];

  logic [7:0] m_level = 8'h00;
  logic [7:0] m_prev  = 8'h00;
  bit         m_held  = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;
  exp_t sbq[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endfunction

  // Value the debounce logic sees at edge t: raw input two edges earlier,
  // forced to 0 if reset cleared the synchronizer in between.
  function automatic logic [7:0] d_at(int t);
    if (t < 3) return 8'h00;
    if (rst_h[t-1] || rst_h[t-2]) return 8'h00;
    return raw_h[t-2];
  endfunction

  // Reference model: a level flips once the last N observed samples all
  // disagree with it; pulses follow from level rises and the held flag.
  always @(posedge clk) begin : model
    logic [7:0] rises;
    logic [7:0] p;
    bit         found;
    bit         flip;
    cyc = cyc + 1;
    if (cyc < MAXC) begin
      raw_h[cyc] = sw_in;
      rst_h[cyc] = reset;
      if (reset) begin
        d_h[cyc] = 8'h00;
        m_level  = 8'h00;
        m_prev   = 8'h00;
        m_held   = 1'b0;
      end else begin
        d_h[cyc] = d_at(cyc);
        rises = m_level & ~m_prev;
        p     = 8'h00;
        p[0]  = rises[0];
        found = 1'b0;
        if (!m_held) begin
          for (int i = 1; i < 8; i++) begin
            if (rises[i] && !found) begin
              p[i]   = 1'b1;
              found  = 1'b1;
              m_held = 1'b1;
            end
          end
        end else if (m_level[7:1] == 7'd0) begin
          m_held = 1'b0;
        end
        if (p != 8'h00) sbq.push_back('{cyc, p});
        m_prev = m_level;
        if (cyc >= N) begin
          for (int b = 0; b < 8; b++) begin
            flip = 1'b1;
            for (int k = 0; k < N; k++) begin
              if (d_h[cyc-k][b] == m_level[b]) flip = 1'b0;
            end
            if (flip) m_level[b] = ~m_level[b];
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (cyc > 0) begin
      chk("sw_level", int'(sw_level), int'(m_level));
      chk("busy", int'(busy), int'(m_held));
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        chk("missed_pulse", 0, int'(sbq[0].val));
        void'(sbq.pop_front());
      end
      if (sw_pulse != 8'h00) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          $display("pulse cycle=%0d val=%02h", cyc, sw_pulse);
          chk("sw_pulse", int'(sw_pulse), int'(sbq[0].val));
          void'(sbq.pop_front());
        end else begin
          chk("unexpected_pulse", int'(sw_pulse), 0);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] m;
    int r;
    int hold;
    reset = 1'b1;
    sw_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(sw_level), 0);
    chk("reset_pulse", int'(sw_pulse), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Single press: level after 2+N edges, pulse one edge later.
    sw_in = 8'h10;
    repeat (5) @(negedge clk);
    chk("lat_level_c5", int'(sw_level), 8'h00);
    @(negedge clk);
    chk("lat_level_c6", int'(sw_level), 8'h10);
    chk("lat_pulse_c6", int'(sw_pulse), 8'h00);
    @(negedge clk);
    chk("lat_pulse_c7", int'(sw_pulse), 8'h10);
    chk("lat_busy_c7", int'(busy), 1);
    @(negedge clk);
    chk("lat_pulse_c8", int'(sw_pulse), 8'h00);

    // Glitch shorter than N on bit 2 is ignored.
    sw_in = 8'h14;
    repeat (3) @(negedge clk);
    sw_in = 8'h10;
    repeat (8) @(negedge clk);
    chk("glitch_level", int'(sw_level), 8'h10);

    // Release: busy drops one edge after the level clears.
    sw_in = 8'h00;
    repeat (6) @(negedge clk);
    chk("rel_level", int'(sw_level), 8'h00);
    chk("rel_busy_hold", int'(busy), 1);
    @(negedge clk);
    chk("rel_busy_drop", int'(busy), 0);

    for (int s = 0; s < 350; s++) begin
      r    = int'($urandom_range(0, 11));
      hold = int'($urandom_range(1, 12));
      if (r == 11) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end else begin
        if (r <= 2) sw_in = 8'h00;
        else if (r <= 7) begin
          m = 8'h01 << $urandom_range(0, 7);
          sw_in = sw_in ^ m;
        end else if (r <= 9) sw_in = 8'($urandom);
        else sw_in = sw_in ^ 8'h01;
        repeat (hold) @(negedge clk);
      end
    end

    sw_in = 8'h00;
    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
